// File: rtl/navigate_ramp_pkg.sv
// Shared types and defaults for the forward/heading navigator.
package nav_pkg;

  typedef enum logic [2:0] {IDLE, HDNG, ACCEL, DEC, DEC_FAST} nav_state_t;

  localparam int          DEF_SPD_W   = 11;
  localparam logic [10:0] DEF_MAX_SPD = 11'h2A0;
  localparam logic [10:0] DEF_MIN_SPD = 11'h0D0;
  localparam int          SIM_STEP    = 24;

  // Simulation builds use a coarse step so a full ramp takes few strobes.
  function automatic int step(input bit fast_sim, input int acc_inc);
    return fast_sim ? SIM_STEP : acc_inc;
  endfunction

endpackage

// File: rtl/navigate_ramp_if.sv
// Command/status bundle between the sequencer, sensors and the navigator.
interface navigate_ramp_if #(
  parameter int SPD_W = 11,
  parameter int CNT_W = 3
);
  logic             strt_hdng;
  logic             strt_mv;
  logic             stp_lft;
  logic             stp_rght;
  logic [CNT_W-1:0] stp_cnt;
  logic             abort;
  logic             hdng_rdy;
  logic             at_hdng;
  logic             lft_opn;
  logic             rght_opn;
  logic             frwrd_opn;
  logic [SPD_W-1:0] frwrd_spd;
  logic             moving;
  logic             en_fusion;
  logic             mv_cmplt;
  logic             mv_err;
  logic             busy;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, stp_cnt, abort,
           hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn,
    input  frwrd_spd, moving, en_fusion, mv_cmplt, mv_err, busy
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, stp_cnt, abort,
           hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn,
    output frwrd_spd, moving, en_fusion, mv_cmplt, mv_err, busy
  );
endinterface

// File: rtl/navigate_ramp_spd_ramp.sv
// Saturating forward-speed register: load, accelerate, slow and fast decelerate,
// all paced by hdng_rdy except the start-of-move load.
module spd_ramp #(
  parameter int               SPD_W     = 11,
  parameter logic [SPD_W-1:0] MAX_SPD   = 11'h2A0,
  parameter logic [SPD_W-1:0] MIN_SPD   = 11'h0D0,
  parameter int               INC_STEP  = 24,
  parameter int               DEC_STEP  = 48,
  parameter int               FDEC_STEP = 192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hdng_rdy,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic             dec_fast,
  output logic [SPD_W-1:0] frwrd_spd,
  output logic             spd_zero
);

  localparam logic [SPD_W:0] INC_W  = INC_STEP[SPD_W:0];
  localparam logic [SPD_W:0] DEC_W  = DEC_STEP[SPD_W:0];
  localparam logic [SPD_W:0] FDEC_W = FDEC_STEP[SPD_W:0];

  logic [SPD_W-1:0] spd;
  logic [SPD_W:0]   sum, sdiff, fdiff;
  logic [SPD_W-1:0] inc_val, slow_val, fast_val;

  // One extra bit of headroom so neither bound can wrap.
  always_comb begin
    sum      = {1'b0, spd} + INC_W;
    sdiff    = {1'b0, spd} - DEC_W;
    fdiff    = {1'b0, spd} - FDEC_W;
    inc_val  = (sum > {1'b0, MAX_SPD}) ? MAX_SPD : sum[SPD_W-1:0];
    slow_val = ({1'b0, spd} > DEC_W)  ? sdiff[SPD_W-1:0] : '0;
    fast_val = ({1'b0, spd} > FDEC_W) ? fdiff[SPD_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      spd <= '0;
    else if (load)
      spd <= MIN_SPD;
    else if (hdng_rdy) begin
      if (dec_fast)
        spd <= fast_val;
      else if (dec)
        spd <= slow_val;
      else if (inc)
        spd <= inc_val;
    end
  end

  assign frwrd_spd = spd;
  assign spd_zero  = (spd == '0);

endmodule

// File: rtl/navigate_ramp.sv
// Forward/heading navigator: move FSM, opening counter, heading timeout and
// edge detection around the spd_ramp speed register.
module navigate_ramp
  import nav_pkg::*;
#(
  parameter int               SPD_W      = DEF_SPD_W,
  parameter logic [SPD_W-1:0] MAX_SPD    = SPD_W'(DEF_MAX_SPD),
  parameter logic [SPD_W-1:0] MIN_SPD    = SPD_W'(DEF_MIN_SPD),
  parameter int               ACC_INC    = 2,
  parameter bit               FAST_SIM   = 1'b1,
  parameter int               DEC_SHIFT  = 1,
  parameter int               FAST_SHIFT = 3,
  parameter int               CNT_W      = 3,
  parameter logic [19:0]      HDNG_TMO   = 20'd1000000
) (
  input logic           clk,
  input logic           rst_n,
  navigate_ramp_if.slave nav
);

  localparam int          STEP     = step(FAST_SIM, ACC_INC);
  localparam logic [19:0] TMO_LAST = HDNG_TMO - 20'd1;
  localparam bit          TMO_EN   = (HDNG_TMO != 20'd0);

  nav_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [19:0]      tmo_cnt;
  logic             lft_prev, rght_prev;
  logic             err_flag, err_nxt;
  logic             qual, tmo_hit;
  logic             spd_load, spd_inc, spd_dec, spd_dec_fast, spd_zero;
  logic [SPD_W-1:0] spd;

  assign qual    = (nav.lft_opn & ~lft_prev & nav.stp_lft) |
                   (nav.rght_opn & ~rght_prev & nav.stp_rght);
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

  // Prev regs reset high so an opening already present is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tmo_cnt   <= '0;
      lft_prev  <= 1'b1;
      rght_prev <= 1'b1;
      err_flag  <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_nxt;
      err_flag  <= err_nxt;
      lft_prev  <= nav.lft_opn;
      rght_prev <= nav.rght_opn;
      if (state == IDLE)
        tmo_cnt <= '0;
      else if (state == HDNG)
        tmo_cnt <= tmo_cnt + 20'd1;
    end
  end

  always_comb begin
    next_state   = state;
    cnt_nxt      = cnt;
    err_nxt      = err_flag;
    spd_load     = 1'b0;
    spd_inc      = 1'b0;
    spd_dec      = 1'b0;
    spd_dec_fast = 1'b0;
    nav.moving   = 1'b0;
    nav.mv_cmplt = 1'b0;
    nav.mv_err   = 1'b0;
    case (state)
      IDLE: begin
        if (nav.strt_hdng)
          next_state = HDNG;
        else if (nav.strt_mv) begin
          next_state = ACCEL;
          spd_load   = 1'b1;
          cnt_nxt    = (nav.stp_cnt == '0) ? CNT_W'(1) : nav.stp_cnt;
        end
      end
      HDNG: begin
        nav.moving = ~nav.at_hdng;
        if (nav.at_hdng) begin
          next_state   = IDLE;
          nav.mv_cmplt = 1'b1;
        end else if (nav.abort || tmo_hit) begin
          next_state   = IDLE;
          nav.mv_cmplt = 1'b1;
          nav.mv_err   = 1'b1;
        end
      end
      ACCEL: begin
        nav.moving = 1'b1;
        spd_inc    = 1'b1;
        if (nav.abort || !nav.frwrd_opn) begin
          next_state = DEC_FAST;
          if (nav.abort)
            err_nxt = 1'b1;
        end else if (qual) begin
          if (cnt <= CNT_W'(1))
            next_state = DEC;
          else
            cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DEC: begin
        nav.moving = 1'b1;
        spd_dec    = 1'b1;
        if (nav.abort) begin
          next_state = DEC_FAST;
          err_nxt    = 1'b1;
        end else if (spd_zero) begin
          next_state   = IDLE;
          nav.mv_cmplt = 1'b1;
        end
      end
      DEC_FAST: begin
        nav.moving   = 1'b1;
        spd_dec_fast = 1'b1;
        if (spd_zero) begin
          next_state   = IDLE;
          nav.mv_cmplt = 1'b1;
          nav.mv_err   = err_flag;
          err_nxt      = 1'b0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  spd_ramp #(
    .SPD_W    (SPD_W),
    .MAX_SPD  (MAX_SPD),
    .MIN_SPD  (MIN_SPD),
    .INC_STEP (STEP),
    .DEC_STEP (STEP << DEC_SHIFT),
    .FDEC_STEP(STEP << FAST_SHIFT)
  ) u_spd_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .hdng_rdy (nav.hdng_rdy),
    .load     (spd_load),
    .inc      (spd_inc),
    .dec      (spd_dec),
    .dec_fast (spd_dec_fast),
    .frwrd_spd(spd),
    .spd_zero (spd_zero)
  );

  assign nav.frwrd_spd = spd;
  assign nav.en_fusion = (spd > (MAX_SPD >> 1));
  assign nav.busy      = (state != IDLE);

endmodule
